// File: rtl/aes_128_result_capture.sv
// aes_128_result_capture: tracks real requests through aes_128's fixed latency and buffers their ciphertexts in a ready/valid FIFO.
// Optional AES_CAPTURE_SIGNATURE_EN adds a rotate-XOR signature over every captured ciphertext.
module aes_128_result_capture #(
    parameter int LATENCY    = 21,
    parameter int DATA_WIDTH = 128,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             issue_valid,
    input  logic [DATA_WIDTH-1:0]            aes_out,
    output logic                             o_valid,
    output logic [DATA_WIDTH-1:0]            o_data,
    input  logic                             o_ready,
    output logic [$clog2(FIFO_DEPTH):0]      fifo_count,
    output logic [$clog2(LATENCY):0]         in_flight,
    output logic [CNT_WIDTH-1:0]             result_count,
    output logic [CNT_WIDTH-1:0]             drop_count,
`ifdef AES_CAPTURE_SIGNATURE_EN
    output logic [DATA_WIDTH-1:0]            signature,
`endif
    output logic                             overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int IW = $clog2(LATENCY) + 1;

    logic [LATENCY-1:0]    dl;
    logic [AW:0]           wr_ptr, rd_ptr;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic                  tap, empty, full, pop, push, drop;

    // Pointers carry a wrap bit so full and empty differ only in that bit.
    assign tap        = dl[LATENCY-1];
    assign empty      = wr_ptr == rd_ptr;
    assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign o_valid    = !empty;
    assign pop        = o_valid && o_ready;
    assign push       = tap && (!full || pop);
    assign drop       = tap && full && !pop;
    assign fifo_count = wr_ptr - rd_ptr;
    assign o_data     = o_valid ? mem[rd_ptr[AW-1:0]] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dl           <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            in_flight    <= '0;
            result_count <= '0;
            drop_count   <= '0;
            overflow     <= 1'b0;
        end else begin
            dl <= {dl[LATENCY-2:0], issue_valid};
            if (issue_valid != tap)
                in_flight <= issue_valid ? in_flight + IW'(1) : in_flight - IW'(1);
            if (pop)
                rd_ptr <= rd_ptr + (AW+1)'(1);
            if (push) begin
                wr_ptr       <= wr_ptr + (AW+1)'(1);
                result_count <= result_count + CNT_WIDTH'(1);
            end
            if (drop) begin
                if (drop_count != '1)
                    drop_count <= drop_count + CNT_WIDTH'(1);
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= aes_out;
    end

`ifdef AES_CAPTURE_SIGNATURE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            signature <= '0;
        else if (push)
            signature <= {signature[DATA_WIDTH-2:0], signature[DATA_WIDTH-1]} ^ aes_out;
    end
`endif
endmodule

// File: tb/tb_aes_128_result_capture.sv
// tb_aes_128_result_capture: directed tests against a queue-based model of the capture block.
// Define AES_CAPTURE_SIGNATURE_EN to also check the signature output.
module tb_aes_128_result_capture;
    localparam int L  = 21;
    localparam int DW = 128;
    localparam int D  = 8;
    localparam int CW = 32;
    localparam logic [DW-1:0] FIPS = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic          clk = 0, rst = 1, issue_valid = 0, o_ready = 0;
    logic [DW-1:0] aes_out = '0;
    logic          o_valid, overflow;
    logic [DW-1:0] o_data;
    logic [3:0]    fifo_count;
    logic [5:0]    in_flight;
    logic [CW-1:0] result_count, drop_count;
`ifdef AES_CAPTURE_SIGNATURE_EN
    logic [DW-1:0] signature;
`endif

    aes_128_result_capture dut (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .aes_out(aes_out),
        .o_valid(o_valid), .o_data(o_data), .o_ready(o_ready),
        .fifo_count(fifo_count), .in_flight(in_flight),
        .result_count(result_count), .drop_count(drop_count),
`ifdef AES_CAPTURE_SIGNATURE_EN
        .signature(signature),
`endif
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] pat(input int n);
        logic [31:0] x;
        x = 32'(n) * 32'h9E3779B9;
        return {x, ~x, x + 32'd1, x ^ 32'h0000FFFF};
    endfunction

    function automatic logic [DW-1:0] rotl1(input logic [DW-1:0] v);
        return {v[DW-2:0], v[DW-1]};
    endfunction

    // Behavioural model: issue edges in a queue, FIFO contents in a queue.
    logic [DW-1:0] mq[$];
    int            iq[$];
    int            pop_rel[$];
    logic [DW-1:0] popped[$];
    int            cyc = 0, first_issue = -1;
    logic [CW-1:0] m_res = 0, m_drop = 0;
    bit            m_ovf = 0, m_pop, m_tap;
    logic [DW-1:0] m_sig = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete(); iq.delete(); pop_rel.delete(); popped.delete();
            first_issue = -1; m_res = 0; m_drop = 0; m_ovf = 0; m_sig = '0;
        end else begin
            m_pop = mq.size() > 0 && o_ready;
            m_tap = iq.size() > 0 && iq[0] == cyc - L;
            if (m_pop) begin
                popped.push_back(mq[0]);
                pop_rel.push_back(cyc - first_issue);
                void'(mq.pop_front());
            end
            if (m_tap) begin
                void'(iq.pop_front());
                if (mq.size() < D) begin
                    mq.push_back(aes_out);
                    m_res++;
                    m_sig = rotl1(m_sig) ^ aes_out;
                end else begin
                    if (m_drop != '1) m_drop++;
                    m_ovf = 1;
                end
            end
            if (issue_valid) begin
                iq.push_back(cyc);
                if (first_issue < 0) first_issue = cyc;
            end
            cyc++;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("o_valid", DW'(o_valid), DW'(mq.size() > 0));
            if (mq.size() > 0) chk("o_data", o_data, mq[0]);
            chk("fifo_count", DW'(fifo_count), DW'(mq.size()));
            chk("in_flight", DW'(in_flight), DW'(iq.size()));
            chk("result_count", DW'(result_count), DW'(m_res));
            chk("drop_count", DW'(drop_count), DW'(m_drop));
            chk("overflow", DW'(overflow), DW'(m_ovf));
`ifdef AES_CAPTURE_SIGNATURE_EN
            chk("signature", signature, m_sig);
`endif
        end
    end

    bit fips = 0;
    task automatic tick();
        @(negedge clk);
        aes_out = fips ? FIPS : pat(cyc);
    endtask

    task automatic reset_dut();
        issue_valid = 0; o_ready = 0;
        rst = 1;
        repeat (2) tick();
        rst = 0;
    endtask

    task automatic outputs_zero(input string tag);
        chk({tag, "_o_valid"}, DW'(o_valid), '0);
        chk({tag, "_o_data"}, o_data, '0);
        chk({tag, "_fifo_count"}, DW'(fifo_count), '0);
        chk({tag, "_in_flight"}, DW'(in_flight), '0);
        chk({tag, "_result_count"}, DW'(result_count), '0);
        chk({tag, "_drop_count"}, DW'(drop_count), '0);
        chk({tag, "_overflow"}, DW'(overflow), '0);
    endtask

    int gap[7] = '{1, 0, 1, 1, 0, 0, 1};
    int gap_exp[4] = '{22, 24, 25, 28};
    int fi;
    logic [DW-1:0] sig8;

    initial begin
        // Reset state
        repeat (2) tick();
        outputs_zero("reset");
        rst = 0;

        // FIPS-197 single request
        reset_dut();
        fips = 1; o_ready = 1;
        tick(); issue_valid = 1; tick(); issue_valid = 0;
        repeat (30) tick();
        chk("fips_pops", DW'(pop_rel.size()), DW'(1));
        chk("fips_edge", DW'(pop_rel.size() > 0 ? pop_rel[0] : -1), DW'(22));
        chk("fips_data", popped.size() > 0 ? popped[0] : '0, FIPS);
        chk("fips_result_count", DW'(result_count), DW'(1));
        chk("fips_in_flight", DW'(in_flight), '0);
        fips = 0;

        // Back-pressure fill
        reset_dut();
        tick(); issue_valid = 1; repeat (10) tick(); issue_valid = 0;
        repeat (25) tick();
        chk("bp_fifo_count", DW'(fifo_count), DW'(8));
        chk("bp_result_count", DW'(result_count), DW'(8));
        chk("bp_drop_count", DW'(drop_count), DW'(2));
        chk("bp_overflow", DW'(overflow), DW'(1));
        fi = first_issue;
        o_ready = 1; repeat (12) tick(); o_ready = 0;
        chk("bp_drained", DW'(popped.size()), DW'(8));
        for (int i = 0; i < 8; i++)
            chk("bp_order", i < popped.size() ? popped[i] : '0, pat(fi + L + i));
        chk("bp_empty", DW'(fifo_count), '0);

        // Full with simultaneous pop on the 9th arrival
        reset_dut();
        tick(); issue_valid = 1; repeat (9) tick(); issue_valid = 0;
        repeat (20) tick();
        chk("fp_prefull", DW'(fifo_count), DW'(8));
        o_ready = 1; tick(); o_ready = 0;
        repeat (3) tick();
        chk("fp_fifo_count", DW'(fifo_count), DW'(8));
        chk("fp_drop_count", DW'(drop_count), '0);
        chk("fp_overflow", DW'(overflow), '0);
        chk("fp_result_count", DW'(result_count), DW'(9));

        // Gapped stream
        reset_dut();
        o_ready = 1; tick();
        for (int i = 0; i < 7; i++) begin
            issue_valid = gap[i][0];
            tick();
        end
        issue_valid = 0;
        repeat (30) tick();
        chk("gap_count", DW'(pop_rel.size()), DW'(4));
        for (int i = 0; i < 4; i++)
            chk("gap_edge", DW'(i < pop_rel.size() ? pop_rel[i] : -1), DW'(gap_exp[i]));

        // Async reset mid-flight
        reset_dut();
        o_ready = 1; tick();
        issue_valid = 1; repeat (5) tick(); issue_valid = 0;
        repeat (4) tick();
        #2 rst = 1;
        #1 outputs_zero("areset");
        #1 rst = 0;
        repeat (40) tick();
        chk("areset_no_output", DW'(pop_rel.size()), '0);
        chk("areset_result_count", DW'(result_count), '0);
        chk("areset_in_flight", DW'(in_flight), '0);

`ifdef AES_CAPTURE_SIGNATURE_EN
        reset_dut();
        tick(); issue_valid = 1; repeat (2) tick(); issue_valid = 0;
        fi = first_issue;
        repeat (25) tick();
        chk("sig_two", signature, rotl1(pat(fi + L)) ^ pat(fi + L + 1));
        issue_valid = 1; repeat (6) tick(); issue_valid = 0;
        repeat (25) tick();
        sig8 = m_sig;
        issue_valid = 1; tick(); issue_valid = 0;
        repeat (25) tick();
        chk("sig_drop_count", DW'(drop_count), DW'(1));
        chk("sig_after_drop", signature, sig8);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
